branch_redirect_ctrl: RTL and testbench

//  Sequences PC redirection for resolved branches and jumps in the RV32I pipeline.

---
 rtl/branch_redirect_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   Resolves conditional branches and jumps in EX under static
//   predict-not-taken. On a taken, aligned target it drives the PC mux with
//   the redirect address and holds it until fetch accepts (PC_READY). It then
//   keeps IF/ID and ID/EX flushed for FLUSH_CYCLES more cycles. While busy,
//   EX inputs are wrong-path and are ignored. Saturating statistics counters.
//
// Ports
//   CLK, RESET              clock, async active-high reset
//   EX_VALID/BRANCH/JUMP    EX-stage instruction qualifiers
//   FUNCT3, ZERO, LT, LTU   branch condition select and ALU compare flags
//   TARGET                  computed branch/jump target
//   PC_READY                fetch accepts NEXT_PC this cycle
//   PC_MUX, NEXT_PC         redirect request to the PC mux
//   FLUSH_IFID, FLUSH_IDEX  pipeline squash
//   BUSY                    controller not idle
//   ILLEGAL, MISALIGN       one-cycle error pulses
//   BR_CNT, TAKEN_CNT       saturating statistics
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EX_VALID,
    input  logic              BRANCH,
    input  logic              JUMP,
    input  logic [2:0]        FUNCT3,
    input  logic              ZERO,
    input  logic              LT,
    input  logic              LTU,
    input  logic [ADDR_W-1:0] TARGET,
    input  logic              PC_READY,
    output logic              PC_MUX,
    output logic [ADDR_W-1:0] NEXT_PC,
    output logic              FLUSH_IFID,
    output logic              FLUSH_IDEX,
    output logic              BUSY,
    output logic              ILLEGAL,
    output logic              MISALIGN,
    output logic [CNT_W-1:0]  BR_CNT,
    output logic [CNT_W-1:0]  TAKEN_CNT
);

    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

    localparam logic [3:0]       FC      = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic              illegal_q, illegal_d;
    logic              misalign_q, misalign_d;

    logic              sample, f3_legal, cond, br_legal, taken, go;
    logic [ADDR_W-1:0] tgt;

    // Decode is only meaningful in IDLE; anything seen while busy is wrong-path.
    always_comb begin
        sample   = (state_q == S_IDLE) && EX_VALID;
        f3_legal = (FUNCT3[2:1] != 2'b01);
        case (FUNCT3)
            3'b000:  cond = ZERO;
            3'b001:  cond = !ZERO;
            3'b100:  cond = LT;
            3'b101:  cond = !LT;
            3'b110:  cond = LTU;
            3'b111:  cond = !LTU;
            default: cond = 1'b0;
        endcase
        br_legal   = sample && BRANCH && !JUMP && f3_legal;
        taken      = (br_legal && cond) || (sample && JUMP && !BRANCH);
        // JALR semantics: bit 0 of the target is always cleared.
        tgt        = TARGET & ~{{(ADDR_W-1){1'b0}}, 1'b1};
        illegal_d  = sample && BRANCH && (JUMP || !f3_legal);
        misalign_d = taken && tgt[1];
        go         = taken && !tgt[1];
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        fcnt_d      = fcnt_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;

        if (br_legal && br_cnt_q != CNT_MAX)
            br_cnt_d = br_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_REDIRECT;
                    target_d = tgt;
                    if (taken_cnt_q != CNT_MAX)
                        taken_cnt_d = taken_cnt_q + 1'b1;
                end
            end
            S_REDIRECT: begin
                if (PC_READY) begin
                    fcnt_d  = FC;
                    state_d = (FC == 4'd0) ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fcnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            fcnt_q      <= 4'd0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            illegal_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            fcnt_q      <= fcnt_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            illegal_q   <= illegal_d;
            misalign_q  <= misalign_d;
        end
    end

    // Outputs decode only registered state, so they fall with an async reset.
    assign PC_MUX     = (state_q == S_REDIRECT);
    assign NEXT_PC    = PC_MUX ? target_q : '0;
    assign BUSY       = (state_q != S_IDLE);
    assign FLUSH_IFID = BUSY;
    assign FLUSH_IDEX = BUSY;
    assign ILLEGAL    = illegal_q;
    assign MISALIGN   = misalign_q;
    assign BR_CNT     = br_cnt_q;
    assign TAKEN_CNT  = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
    localparam int AW = 32;
    localparam int FC = 2;

    logic CLK = 1'b0;
    logic RESET, EX_VALID, BRANCH, JUMP, ZERO, LT, LTU, PC_READY;
    logic [2:0] FUNCT3;
    logic [AW-1:0] TARGET;

    logic PC_MUX, FLUSH_IFID, FLUSH_IDEX, BUSY, ILLEGAL, MISALIGN;
    logic [AW-1:0] NEXT_PC;
    logic [15:0] BR_CNT, TAKEN_CNT;

    logic PC_MUX2, FLUSH_IFID2, FLUSH_IDEX2, BUSY2, ILLEGAL2, MISALIGN2;
    logic [AW-1:0] NEXT_PC2;
    logic [1:0] BR_CNT2, TAKEN_CNT2;

    wire [5:0] ctl = {PC_MUX, FLUSH_IFID, FLUSH_IDEX, BUSY, ILLEGAL, MISALIGN};

    branch_redirect_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BRANCH(BRANCH), .JUMP(JUMP),
        .FUNCT3(FUNCT3), .ZERO(ZERO), .LT(LT), .LTU(LTU), .TARGET(TARGET),
        .PC_READY(PC_READY), .PC_MUX(PC_MUX), .NEXT_PC(NEXT_PC),
        .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX), .BUSY(BUSY),
        .ILLEGAL(ILLEGAL), .MISALIGN(MISALIGN), .BR_CNT(BR_CNT), .TAKEN_CNT(TAKEN_CNT));

    // Narrow-counter copy on the same stimulus, for saturation.
    branch_redirect_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BRANCH(BRANCH), .JUMP(JUMP),
        .FUNCT3(FUNCT3), .ZERO(ZERO), .LT(LT), .LTU(LTU), .TARGET(TARGET),
        .PC_READY(PC_READY), .PC_MUX(PC_MUX2), .NEXT_PC(NEXT_PC2),
        .FLUSH_IFID(FLUSH_IFID2), .FLUSH_IDEX(FLUSH_IDEX2), .BUSY(BUSY2),
        .ILLEGAL(ILLEGAL2), .MISALIGN(MISALIGN2), .BR_CNT(BR_CNT2), .TAKEN_CNT(TAKEN_CNT2));

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nfail = 0;

    // Reference model: operands, pending redirect, remaining flush cycles.
    logic [31:0] opa, opb;
    bit m_redir, m_ill, m_mis;
    int m_flush, m_br, m_tk;
    logic [AW-1:0] m_tgt;

    function automatic bit cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        opa = a; opb = b;
        ZERO = (a == b);
        LT = ($signed(a) < $signed(b));
        LTU = (a < b);
    endtask

    task automatic model_reset();
        m_redir = 0; m_ill = 0; m_mis = 0; m_flush = 0; m_br = 0; m_tk = 0; m_tgt = '0;
    endtask

    task automatic model_step();
        bit busy, take, newr;
        logic [AW-1:0] t;
        busy = m_redir || (m_flush > 0);
        take = 0; newr = 0; m_ill = 0; m_mis = 0;
        if (!busy && EX_VALID) begin
            if (BRANCH && JUMP) m_ill = 1;
            else if (BRANCH) begin
                if (FUNCT3 == 3'd2 || FUNCT3 == 3'd3) m_ill = 1;
                else begin
                    m_br++;
                    take = cond_of(FUNCT3, opa, opb);
                end
            end else if (JUMP) take = 1;
        end
        if (take) begin
            t = {TARGET[AW-1:1], 1'b0};
            if (t[1]) m_mis = 1;
            else begin
                m_tk++; newr = 1; m_tgt = t;
            end
        end
        if (m_redir) begin
            if (PC_READY) begin m_redir = 0; m_flush = FC; end
        end else if (m_flush > 0) m_flush--;
        if (newr) m_redir = 1;
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic clr();
        EX_VALID = 0; BRANCH = 0; JUMP = 0; FUNCT3 = 3'd0; TARGET = '0; PC_READY = 1;
        set_ops(32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        clr();
        RESET = 1;
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        nchk++; if (ctl !== 6'b0) begin nfail++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
        nchk++; if (NEXT_PC !== '0) begin nfail++; $display("FAIL reset_next_pc got=%h exp=0", NEXT_PC); end
        nchk++; if (BR_CNT !== 16'd0 || TAKEN_CNT !== 16'd0) begin nfail++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", BR_CNT, TAKEN_CNT); end
    endtask

    task automatic test_beq_taken();
        apply_reset();
        EX_VALID = 1; BRANCH = 1; FUNCT3 = 3'd0; set_ops(32'd7, 32'd7); TARGET = 32'h100; PC_READY = 1;
        cyc(); clr();
        nchk++; if (ctl !== 6'b111100) begin nfail++; $display("FAIL beq_redirect got=%b exp=111100", ctl); end
        nchk++; if (NEXT_PC !== 32'h100) begin nfail++; $display("FAIL beq_next_pc got=%h exp=100", NEXT_PC); end
        cyc();
        nchk++; if (ctl !== 6'b011100) begin nfail++; $display("FAIL beq_flush1 got=%b exp=011100", ctl); end
        cyc();
        nchk++; if (ctl !== 6'b011100) begin nfail++; $display("FAIL beq_flush2 got=%b exp=011100", ctl); end
        cyc();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL beq_idle got=%b exp=000000", ctl); end
        nchk++; if (BR_CNT !== 16'd1 || TAKEN_CNT !== 16'd1) begin nfail++;
            $display("FAIL beq_cnt got=%0d/%0d exp=1/1", BR_CNT, TAKEN_CNT); end
    endtask

    task automatic test_bne_not_taken();
        apply_reset();
        EX_VALID = 1; BRANCH = 1; FUNCT3 = 3'd1; set_ops(32'd9, 32'd9); TARGET = 32'h180;
        cyc(); clr();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL bne_ctl got=%b exp=000000", ctl); end
        cyc();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL bne_ctl2 got=%b exp=000000", ctl); end
        nchk++; if (BR_CNT !== 16'd1 || TAKEN_CNT !== 16'd0) begin nfail++;
            $display("FAIL bne_cnt got=%0d/%0d exp=1/0", BR_CNT, TAKEN_CNT); end
    endtask

    task automatic test_jal_stall();
        apply_reset();
        EX_VALID = 1; JUMP = 1; FUNCT3 = 3'd5; TARGET = 32'h204; PC_READY = 0;
        cyc();
        // wrong-path branch that would be taken if it were sampled
        JUMP = 0; BRANCH = 1; FUNCT3 = 3'd0; set_ops(32'd1, 32'd1); TARGET = 32'h800;
        for (int i = 0; i < 3; i++) begin
            nchk++; if (ctl !== 6'b111100 || NEXT_PC !== 32'h204) begin nfail++;
                $display("FAIL jal_hold[%0d] got=%b/%h exp=111100/204", i, ctl, NEXT_PC); end
            EX_VALID = (i != 1);
            PC_READY = (i == 2);
            cyc();
        end
        clr();
        nchk++; if (ctl !== 6'b011100) begin nfail++; $display("FAIL jal_release got=%b exp=011100", ctl); end
        nchk++; if (BR_CNT !== 16'd0 || TAKEN_CNT !== 16'd1) begin nfail++;
            $display("FAIL jal_cnt got=%0d/%0d exp=0/1", BR_CNT, TAKEN_CNT); end
        repeat (2) cyc();
    endtask

    task automatic test_jalr_misalign();
        apply_reset();
        EX_VALID = 1; JUMP = 1; TARGET = 32'h0000_0203;
        cyc(); clr();
        nchk++; if (ctl !== 6'b000001) begin nfail++; $display("FAIL misalign_pulse got=%b exp=000001", ctl); end
        cyc();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL misalign_clear got=%b exp=000000", ctl); end
        nchk++; if (TAKEN_CNT !== 16'd0) begin nfail++; $display("FAIL misalign_cnt got=%0d exp=0", TAKEN_CNT); end
    endtask

    task automatic test_illegal();
        apply_reset();
        EX_VALID = 1; BRANCH = 1; FUNCT3 = 3'd2; set_ops(32'd3, 32'd3); TARGET = 32'h40;
        cyc(); clr();
        nchk++; if (ctl !== 6'b000010) begin nfail++; $display("FAIL illegal_f3 got=%b exp=000010", ctl); end
        cyc();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL illegal_clear got=%b exp=000000", ctl); end
        EX_VALID = 1; BRANCH = 1; JUMP = 1; FUNCT3 = 3'd0; set_ops(32'd3, 32'd3); TARGET = 32'h40;
        cyc(); clr();
        nchk++; if (ctl !== 6'b000010) begin nfail++; $display("FAIL illegal_bj got=%b exp=000010", ctl); end
        nchk++; if (BR_CNT !== 16'd0 || TAKEN_CNT !== 16'd0) begin nfail++;
            $display("FAIL illegal_cnt got=%0d/%0d exp=0/0", BR_CNT, TAKEN_CNT); end
        cyc();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        EX_VALID = 1; JUMP = 1; TARGET = 32'h500; PC_READY = 1;
        cyc();
        nchk++; if (ctl !== 6'b111100 || NEXT_PC !== 32'h500) begin nfail++;
            $display("FAIL b2b_first got=%b/%h exp=111100/500", ctl, NEXT_PC); end
        TARGET = 32'h600;
        cyc(); cyc(); cyc();
        nchk++; if (ctl !== 6'b000000) begin nfail++; $display("FAIL b2b_idle got=%b exp=000000", ctl); end
        cyc(); clr();
        nchk++; if (ctl !== 6'b111100 || NEXT_PC !== 32'h600) begin nfail++;
            $display("FAIL b2b_second got=%b/%h exp=111100/600", ctl, NEXT_PC); end
        nchk++; if (TAKEN_CNT !== 16'd2) begin nfail++; $display("FAIL b2b_cnt got=%0d exp=2", TAKEN_CNT); end
        repeat (3) cyc();
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        EX_VALID = 1; JUMP = 1; TARGET = 32'h300; PC_READY = 1;
        cyc(); clr(); cyc();
        nchk++; if (ctl !== 6'b011100) begin nfail++; $display("FAIL midrst_pre got=%b exp=011100", ctl); end
        #2 RESET = 1;
        #1;
        nchk++; if (ctl !== 6'b0 || NEXT_PC !== '0 || TAKEN_CNT !== 16'd0) begin nfail++;
            $display("FAIL midrst_async got=%b/%h/%0d exp=000000/0/0", ctl, NEXT_PC, TAKEN_CNT); end
        @(posedge CLK); #1 RESET = 0;
        model_reset();
        cyc();
        nchk++; if (ctl !== 6'b0) begin nfail++; $display("FAIL midrst_after got=%b exp=000000", ctl); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            EX_VALID = 1; JUMP = 1; TARGET = 32'h400 + 32'(i * 8); PC_READY = 1;
            cyc(); clr();
            repeat (3) cyc();
        end
        nchk++; if (TAKEN_CNT2 !== 2'd3) begin nfail++; $display("FAIL sat_narrow got=%0d exp=3", TAKEN_CNT2); end
        nchk++; if (TAKEN_CNT !== 16'd5) begin nfail++; $display("FAIL sat_wide got=%0d exp=5", TAKEN_CNT); end
    endtask

    task automatic test_random();
        int kind;
        bit busy;
        logic [31:0] a, b;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            EX_VALID = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 9);
            BRANCH = (kind == 0) || (kind >= 4);
            JUMP = (kind <= 3);
            FUNCT3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_ops(a, b);
            TARGET = $urandom;
            if ($urandom_range(0, 1) != 0) TARGET[1] = 1'b0;
            PC_READY = ($urandom_range(0, 2) != 0);
            cyc();
            busy = m_redir || (m_flush > 0);
            nchk++; if (ctl !== {m_redir, busy, busy, busy, m_ill, m_mis}) begin nfail++;
                $display("FAIL rnd_ctl[%0d] got=%b exp=%b", n, ctl, {m_redir, busy, busy, busy, m_ill, m_mis}); end
            if (m_redir) begin
                nchk++; if (NEXT_PC !== m_tgt) begin nfail++;
                    $display("FAIL rnd_next_pc[%0d] got=%h exp=%h", n, NEXT_PC, m_tgt); end
            end
            nchk++; if (int'(BR_CNT) != sat(m_br, 16) || int'(TAKEN_CNT) != sat(m_tk, 16)) begin nfail++;
                $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, BR_CNT, TAKEN_CNT, sat(m_br, 16), sat(m_tk, 16)); end
            nchk++; if (int'(BR_CNT2) != sat(m_br, 2) || int'(TAKEN_CNT2) != sat(m_tk, 2)) begin nfail++;
                $display("FAIL rnd_cnt_sat[%0d] got=%0d/%0d exp=%0d/%0d", n, BR_CNT2, TAKEN_CNT2, sat(m_br, 2), sat(m_tk, 2)); end
        end
        clr();
    endtask

    initial begin
        RESET = 1;
        clr();
        model_reset();
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_jal_stall();
        test_jalr_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
